adder_arbiter: RTL

Round-robin arbiter that shares one single-cycle `adder` instance among `g_num_req` requesters. Sits between the requesters and the adder: accepts one operand pair at a time, drives the adder's `i_valid/i_A/i_B`, captures `o_valid/o_C`, and returns the sum to the originating requester over a valid/ready response channel. One operation is in flight at a time.

---
 rtl/adder_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/adder_arbiter.sv
// Purpose: round-robin arbiter sharing one registered adder among g_num_req requesters, one op in flight.
// Latency: accept at edge T, adder issue in T+1, adder result in T+2, response valid in T+3.
// Backpressure: response is held in RESP until the owner's ready; no new request is accepted meanwhile.
module adder_arbiter #(
    parameter int g_data_width = 8,
    parameter int g_num_req    = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [g_num_req-1:0]              i_req_valid,
    input  logic [g_num_req*g_data_width-1:0] i_req_A,
    input  logic [g_num_req*g_data_width-1:0] i_req_B,
    output logic [g_num_req-1:0]              o_req_ready,
    output logic [g_num_req-1:0]              o_rsp_valid,
    output logic [g_data_width:0]             o_rsp_C,
    input  logic [g_num_req-1:0]              i_rsp_ready,
    output logic                              o_add_valid,
    output logic [g_data_width-1:0]           o_add_A,
    output logic [g_data_width-1:0]           o_add_B,
    input  logic                              i_add_valid,
    input  logic [g_data_width:0]             i_add_C,
    output logic                              o_busy,
    output logic                              o_err
);

    localparam int IW = $clog2(g_num_req);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [IW-1:0] grant_q;
    logic [IW-1:0] last_grant_q;
    logic [IW-1:0] win_idx;
    logic          win_found;
    int            cand;
    logic          accept;

    // Round-robin search: first valid requester after last_grant, wrapping modulo N.
    always_comb begin
        win_idx   = last_grant_q;
        win_found = 1'b0;
        cand      = 0;
        for (int i = 1; i <= g_num_req; i++) begin
            cand = (int'(last_grant_q) + i) % g_num_req;
            if (!win_found && i_req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = IW'(cand);
            end
        end
    end

    // Transfer happens whenever IDLE sees any request: ready goes only to a valid winner.
    assign accept = (state_q == ST_IDLE) && win_found;
    assign o_busy = (state_q != ST_IDLE);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs; ready is masked by reset so it is low while reset is held.
    always_comb begin
        state_d     = state_q;
        o_req_ready = '0;
        o_add_valid = 1'b0;
        o_rsp_valid = '0;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    o_req_ready[win_idx] = i_rst_n;
                    state_d              = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_add_valid = 1'b1;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_add_valid) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                o_rsp_valid[grant_q] = 1'b1;
                if (i_rsp_ready[grant_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand/grant capture, result capture, priority pointer update and sticky error flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            grant_q      <= '0;
            last_grant_q <= IW'(g_num_req - 1);
            o_add_A      <= '0;
            o_add_B      <= '0;
            o_rsp_C      <= '0;
            o_err        <= 1'b0;
        end else begin
            if (accept) begin
                grant_q <= win_idx;
                o_add_A <= i_req_A[int'(win_idx)*g_data_width +: g_data_width];
                o_add_B <= i_req_B[int'(win_idx)*g_data_width +: g_data_width];
            end
            if (state_q == ST_WAIT && i_add_valid) begin
                o_rsp_C <= i_add_C;
            end
            if (state_q == ST_RESP && i_rsp_ready[grant_q]) begin
                last_grant_q <= grant_q;
            end
            // A result arriving outside WAIT was never requested: flag it and drop it.
            if (i_add_valid && state_q != ST_WAIT) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule
